char_text_buffer: RTL and testbench

Writable, parametrised character-code buffer for the on-screen text layers. It replaces fixed per-screen character ROMs with one RAM-backed grid of COLS x ROWS character codes. The game logic writes cells at run time, and the draw_char pipeline reads them with fixed one-cycle latency. A built-in sequencer clears the grid after reset and on request; an optional sequencer scrolls the grid up by one row.

---
 rtl/vga_pkg.sv | 17 +
 rtl/text_buf_ram.sv | 38 +++
 rtl/char_text_buffer.sv | 170 +++++++++++++++++
 tb/tb_char_text_buffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: character codes and text-buffer sequencer states.
package vga_pkg;

    localparam int CHAR_CODE_W = 7;

    localparam logic [CHAR_CODE_W-1:0] Spc = 7'h00;

    localparam logic [CHAR_CODE_W-1:0] TEXT_BUF_CLEAR_CODE = Spc;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        CLEAR  = 2'd2,
        SCROLL = 2'd3
    } text_buf_state_t;

endpackage

// File: rtl/text_buf_ram.sv
// DEPTH x WIDTH block RAM: read-first display read port plus an internal write port.
// The internal port also gains a synchronous read when TEXT_BUF_SCROLL_EN is defined.
module text_buf_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 7,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
`ifdef TEXT_BUF_SCROLL_EN
    input  logic [AW-1:0]    int_rd_addr,
    output logic [WIDTH-1:0] int_rd_dat,
`endif
    input  logic [WIDTH-1:0] wr_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        rd_dat <= mem[rd_addr];
    end

`ifdef TEXT_BUF_SCROLL_EN
    always_ff @(posedge clk) begin
        int_rd_dat <= mem[int_rd_addr];
    end
`endif

endmodule

// File: rtl/char_text_buffer.sv
// COLS x ROWS character-code grid with 1-cycle display reads and a clear/init sweep sequencer.
// Defining TEXT_BUF_SCROLL_EN adds scroll_req and a one-row scroll-up sweep.
module char_text_buffer
    import vga_pkg::*;
#(
    parameter int                COLS       = 16,
    parameter int                ROWS       = 16,
    parameter int                CODE_W     = 7,
    parameter logic [CODE_W-1:0] CLEAR_CODE = CODE_W'(TEXT_BUF_CLEAR_CODE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(COLS)-1:0] rd_x,
    input  logic [$clog2(ROWS)-1:0] rd_y,
    output logic [CODE_W-1:0]       rd_code,
    input  logic                    wr_en,
    input  logic [$clog2(COLS)-1:0] wr_x,
    input  logic [$clog2(ROWS)-1:0] wr_y,
    input  logic [CODE_W-1:0]       wr_code,
    input  logic                    clr_req,
`ifdef TEXT_BUF_SCROLL_EN
    input  logic                    scroll_req,
`endif
    output logic                    busy,
    output logic                    done
);

    localparam int N  = COLS * ROWS;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    text_buf_state_t state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              done_nxt;

    logic              rd_ok, wr_ok, rd_force;
    logic [AW-1:0]     rd_lin, wr_lin, rd_addr;
    logic [CODE_W-1:0] ram_rd_dat;

    logic              seq_we;
    logic [AW-1:0]     seq_addr;
    logic [CODE_W-1:0] seq_dat;

    logic              ram_we;
    logic [AW-1:0]     ram_wa;
    logic [CODE_W-1:0] ram_wd;

`ifdef TEXT_BUF_SCROLL_EN
    logic              pend, pend_nxt;
    logic [AW-1:0]     int_raddr;
    logic [CODE_W-1:0] int_rdat;
`endif

    // Range checks guard non-power-of-two grids where the address fields can overshoot.
    assign rd_ok = (int'(rd_x) < COLS) && (int'(rd_y) < ROWS);
    assign wr_ok = (int'(wr_x) < COLS) && (int'(wr_y) < ROWS);

    assign rd_lin  = AW'(rd_y) * AW'(COLS) + AW'(rd_x);
    assign wr_lin  = AW'(wr_y) * AW'(COLS) + AW'(wr_x);
    assign rd_addr = rd_ok ? rd_lin : '0;

    assign ram_we = (state == IDLE) ? (wr_en && wr_ok) : seq_we;
    assign ram_wa = (state == IDLE) ? wr_lin : seq_addr;
    assign ram_wd = (state == IDLE) ? wr_code : seq_dat;

    assign busy    = (state != IDLE);
    assign rd_code = rd_force ? CLEAR_CODE : ram_rd_dat;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        seq_we    = 1'b0;
        seq_addr  = AW'(cnt);
        seq_dat   = CLEAR_CODE;
`ifdef TEXT_BUF_SCROLL_EN
        pend_nxt  = 1'b0;
        int_raddr = '0;
`endif
        case (state)
            INIT, CLEAR: begin
                if (cnt == CW'(N)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    seq_we  = 1'b1;
                    cnt_nxt = cnt + CW'(1);
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
`ifdef TEXT_BUF_SCROLL_EN
                else if (scroll_req) begin
                    state_nxt = SCROLL;
                    cnt_nxt   = '0;
                end
`endif
            end
`ifdef TEXT_BUF_SCROLL_EN
            // cnt is the read index; the write to cell cnt-1 lags by the RAM read latency.
            SCROLL: begin
                seq_addr = AW'(cnt - CW'(1));
                seq_dat  = (cnt > CW'(N - COLS)) ? CLEAR_CODE : int_rdat;
                if (cnt == CW'(N)) begin
                    if (pend) begin
                        seq_we = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    seq_we   = pend;
                    pend_nxt = 1'b1;
                    cnt_nxt  = cnt + CW'(1);
                    if (cnt < CW'(N - COLS)) begin
                        int_raddr = AW'(cnt) + AW'(COLS);
                    end
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            cnt      <= '0;
            done     <= 1'b0;
            rd_force <= 1'b1;
`ifdef TEXT_BUF_SCROLL_EN
            pend     <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            done     <= done_nxt;
            rd_force <= !rd_ok || (state == INIT);
`ifdef TEXT_BUF_SCROLL_EN
            pend     <= pend_nxt;
`endif
        end
    end

    text_buf_ram #(
        .DEPTH (N),
        .WIDTH (CODE_W),
        .AW    (AW)
    ) u_ram (
        .clk         (clk),
        .rd_addr     (rd_addr),
        .rd_dat      (ram_rd_dat),
        .wr_en       (ram_we),
        .wr_addr     (ram_wa),
`ifdef TEXT_BUF_SCROLL_EN
        .int_rd_addr (int_raddr),
        .int_rd_dat  (int_rdat),
`endif
        .wr_dat      (ram_wd)
    );

endmodule

// File: tb/tb_char_text_buffer.sv
// Randomized scoreboard bench for char_text_buffer on a 12x10 grid (exercises out-of-range addresses).
module tb_char_text_buffer;

    localparam int COLS = 12;
    localparam int ROWS = 10;
    localparam int N    = COLS * ROWS;
    localparam int XW   = $clog2(COLS);
    localparam int YW   = $clog2(ROWS);
    localparam logic [6:0] CLR = 7'h00;
`ifdef TEXT_BUF_SCROLL_EN
    localparam bit SCROLL_ON = 1'b1;
`else
    localparam bit SCROLL_ON = 1'b0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_INIT   = 1;
    localparam int M_CLEAR  = 2;
    localparam int M_SCROLL = 3;

    logic          clk;
    logic          rst;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [6:0]    rd_code;
    logic          wr_en;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [6:0]    wr_code;
    logic          clr_req;
`ifdef TEXT_BUF_SCROLL_EN
    logic          scroll_req;
`endif
    logic          busy;
    logic          done;

    char_text_buffer #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_code    (rd_code),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_code    (wr_code),
        .clr_req    (clr_req),
`ifdef TEXT_BUF_SCROLL_EN
        .scroll_req (scroll_req),
`endif
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] rd;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;

    // Reference model: grid contents plus sequencer mode and edges elapsed since it started.
    logic [6:0] mm   [N];
    logic [6:0] snap [N];
    int         mode = M_INIT;
    int         t    = 0;

    function automatic int r16();
        return int'($urandom_range(0, 15));
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step(input bit r, input bit we, input int wx, input int wy, input int code,
                        input bit clr, input bit scr, input int rx, input int ry);
        exp_t e;
        int   j;
        rst     = r;
        wr_en   = we;
        wr_x    = XW'(wx);
        wr_y    = YW'(wy);
        wr_code = 7'(code);
        clr_req = clr;
`ifdef TEXT_BUF_SCROLL_EN
        scroll_req = scr;
`endif
        rd_x    = XW'(rx);
        rd_y    = YW'(ry);
        if (r) begin
            mode   = M_INIT;
            t      = 0;
            e.rd   = CLR;
            e.busy = 1'b1;
            e.done = 1'b0;
        end else begin
            e.rd   = (mode == M_INIT || rx >= COLS || ry >= ROWS) ? CLR : mm[ry * COLS + rx];
            e.done = 1'b0;
            if (mode == M_IDLE) begin
                if (we && wx < COLS && wy < ROWS) mm[wy * COLS + wx] = 7'(code);
                if (clr) begin
                    mode = M_CLEAR;
                    t    = 0;
                end else if (scr && SCROLL_ON) begin
                    mode = M_SCROLL;
                    t    = 0;
                    snap = mm;
                end
            end else begin
                t++;
                if (mode == M_SCROLL) begin
                    if (t >= 2 && t <= N + 1) begin
                        j     = t - 2;
                        mm[j] = (j < N - COLS) ? snap[j + COLS] : CLR;
                    end else if (t == N + 2) begin
                        mode   = M_IDLE;
                        e.done = 1'b1;
                    end
                end else begin
                    if (t <= N) mm[t - 1] = CLR;
                    else begin
                        mode   = M_IDLE;
                        e.done = 1'b1;
                    end
                end
            end
            e.busy = (mode != M_IDLE);
        end
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic rand_step(input bit r, input bit req_en);
        bit c, s;
        c = req_en && ($urandom_range(0, 63) == 0);
        s = req_en && ($urandom_range(0, 63) == 0);
        step(r, rbit(), r16(), r16(), int'($urandom_range(0, 127)), c, s, r16(), r16());
    endtask

    // Sweeps are ignored-input windows, so random writes and requests go in while busy.
    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (mode != M_IDLE && n < budget) begin
            step(1'b0, rbit(), r16(), r16(), int'($urandom_range(0, 127)),
                 rbit(), rbit(), r16(), r16());
            n++;
        end
    endtask

    task automatic read_all();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, x, y);
    endtask

    task automatic fill_pattern();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                step(1'b0, 1'b1, x, y, y * COLS + x + 1, 1'b0, 1'b0, r16(), r16());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_code", 32'(rd_code), 32'(e.rd));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("done", 32'(done), 32'(e.done));
            end
        end
    end

    initial begin : driver
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_x    = '0;
        wr_y    = '0;
        wr_code = '0;
        clr_req = 1'b0;
`ifdef TEXT_BUF_SCROLL_EN
        scroll_req = 1'b0;
`endif
        rd_x    = '0;
        rd_y    = '0;
        @(negedge clk);

        repeat (3) rand_step(1'b1, 1'b1);
        run_until_idle(N + 10);
        read_all();

        step(1'b0, 1'b1, 3, 5, 'h41, 1'b0, 1'b0, 3, 5);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 3, 5);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 3, 5);

        repeat (400) rand_step(1'b0, 1'b1);
        run_until_idle(N + 10);

        fill_pattern();
        step(1'b0, 1'b1, 2, 2, 'h33, 1'b1, 1'b0, 2, 2);
        run_until_idle(N + 10);
        read_all();

        fill_pattern();
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b1, 0, 0);
        run_until_idle(N + 10);
        read_all();

        fill_pattern();
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 1);
        run_until_idle(N + 10);
        read_all();

        fill_pattern();
        step(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
        repeat (100) rand_step(1'b0, 1'b1);
        step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        run_until_idle(N + 10);
        read_all();

        fill_pattern();
        step(1'b0, 1'b1, 12, 3, 'h55, 1'b0, 1'b0, 0, 4);
        step(1'b0, 1'b1, 4, 10, 'h56, 1'b0, 1'b0, 12, 3);
        step(1'b0, 1'b1, 15, 15, 'h57, 1'b0, 1'b0, 4, 10);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 4);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 4, 9);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 11, 9);

        repeat (200) rand_step(1'b0, 1'b1);
        run_until_idle(N + 10);
        read_all();

        repeat (2) @(negedge clk);
        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
